// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and load returns onto the regfile write port,
// formats load data, buffers one load on collisions and tracks outstanding loads.
module writeback_unit #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_SEL-1:0]   alu_rd,
  input  logic [WORD_SIZE-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_SEL-1:0]   ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic [WORD_SIZE-1:0] ld_rdata,
  input  logic                 ld_issue,
  input  logic [REG_SEL-1:0]   ld_issue_rd,
  output logic                 wCtrl,
  output logic [REG_SEL-1:0]   wSel,
  output logic [WORD_SIZE-1:0] wData,
  output logic                 ld_err,
  output logic [NUM_REGS-1:0]  pend_mask
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state, state_d;
  logic [REG_SEL-1:0]   buf_rd, buf_rd_d;
  logic [WORD_SIZE-1:0] buf_data, buf_data_d;
  logic                 buf_err, buf_err_d;
  logic                 wctrl_d, err_d;
  logic [REG_SEL-1:0]   wsel_d;
  logic [WORD_SIZE-1:0] wdata_d;
  logic [NUM_REGS-1:0]  pend_d;

  logic                 accept;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] fmt_data;
  logic                 fmt_err;
  logic                 emit_ld, emit_err;
  logic [REG_SEL-1:0]   emit_rd;
  logic [WORD_SIZE-1:0] emit_data;

  // Lane select, extension and alignment/legality check of the incoming load
  always_comb begin
    ld_byte  = ld_rdata[7:0];
    fmt_data = '0;
    fmt_err  = 1'b0;
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'b000: fmt_data = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b100: fmt_data = {{(WORD_SIZE-8){1'b0}}, ld_byte};
      3'b001: begin
        fmt_data = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
        fmt_err  = ld_addr_lo[0];
      end
      3'b101: begin
        fmt_data = {{(WORD_SIZE-16){1'b0}}, ld_half};
        fmt_err  = ld_addr_lo[0];
      end
      3'b010: begin
        fmt_data = ld_rdata;
        fmt_err  = (ld_addr_lo != 2'd0);
      end
      default: fmt_err = 1'b1;
    endcase
  end

  // Write-port arbitration, hold buffer FSM and scoreboard next state
  always_comb begin
    state_d    = state;
    buf_rd_d   = buf_rd;
    buf_data_d = buf_data;
    buf_err_d  = buf_err;
    wctrl_d    = 1'b0;
    wsel_d     = wSel;
    wdata_d    = wData;
    err_d      = 1'b0;
    pend_d     = pend_mask;
    emit_ld    = 1'b0;
    emit_err   = fmt_err;
    emit_rd    = ld_rd;
    emit_data  = fmt_data;

    ld_ready = rst && (state == EMPTY);
    accept   = ld_valid && ld_ready;

    if (alu_valid) begin
      if (alu_rd != '0) begin
        wctrl_d = 1'b1;
        wsel_d  = alu_rd;
        wdata_d = alu_data;
      end
      if (accept) begin
        state_d    = FULL;
        buf_rd_d   = ld_rd;
        buf_data_d = fmt_data;
        buf_err_d  = fmt_err;
      end
    end else if (state == FULL) begin
      state_d   = EMPTY;
      emit_ld   = 1'b1;
      emit_rd   = buf_rd;
      emit_data = buf_data;
      emit_err  = buf_err;
    end else if (accept) begin
      emit_ld = 1'b1;
    end

    if (emit_ld) begin
      pend_d[emit_rd] = 1'b0;
      if (emit_err) begin
        err_d = 1'b1;
      end else if (emit_rd != '0) begin
        wctrl_d = 1'b1;
        wsel_d  = emit_rd;
        wdata_d = emit_data;
      end
    end

    // A new issue to the same register outranks the completing load
    if (ld_issue && (ld_issue_rd != '0)) pend_d[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      buf_rd    <= '0;
      buf_data  <= '0;
      buf_err   <= 1'b0;
      wCtrl     <= 1'b0;
      wSel      <= '0;
      wData     <= '0;
      ld_err    <= 1'b0;
      pend_mask <= '0;
    end else begin
      state     <= state_d;
      buf_rd    <= buf_rd_d;
      buf_data  <= buf_data_d;
      buf_err   <= buf_err_d;
      wCtrl     <= wctrl_d;
      wSel      <= wsel_d;
      wData     <= wdata_d;
      ld_err    <= err_d;
      pend_mask <= pend_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: ALU path, load formatting,
// collision buffering, scoreboard, load errors and asynchronous reset.
module tb_writeback_unit;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_SEL   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 alu_valid;
  logic [REG_SEL-1:0]   alu_rd;
  logic [WORD_SIZE-1:0] alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_SEL-1:0]   ld_rd;
  logic [2:0]           ld_funct3;
  logic [1:0]           ld_addr_lo;
  logic [WORD_SIZE-1:0] ld_rdata;
  logic                 ld_issue;
  logic [REG_SEL-1:0]   ld_issue_rd;
  logic                 wCtrl;
  logic [REG_SEL-1:0]   wSel;
  logic [WORD_SIZE-1:0] wData;
  logic                 ld_err;
  logic [NUM_REGS-1:0]  pend_mask;

  int n_cmp = 0;
  int n_mis = 0;

  writeback_unit #(.WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .REG_SEL(REG_SEL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .wCtrl(wCtrl), .wSel(wSel), .wData(wData),
    .ld_err(ld_err), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_funct3   = '0;
    ld_addr_lo  = '0;
    ld_rdata    = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
  endtask

  task automatic load_in(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] data);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_rdata   = data;
  endtask

  task automatic alu_in(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue    = 1'b1;
    ld_issue_rd = rd;
  endtask

  logic [2:0]  fv_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  fv_lo  [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] fv_exp [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F81, 32'h80FF_7F81};

  initial begin
    rst = 1'b0;
    idle();

    // Reset values
    repeat (3) tick();
    check("rst_wctrl", 64'(wCtrl), 64'd0);
    check("rst_wsel", 64'(wSel), 64'd0);
    check("rst_wdata", 64'(wData), 64'd0);
    check("rst_lderr", 64'(ld_err), 64'd0);
    check("rst_pend", 64'(pend_mask), 64'd0);
    check("rst_ready", 64'(ld_ready), 64'd0);
    rst = 1'b1;

    // ALU path and x0 suppression
    alu_in(5'd5, 32'h1234_5678);
    tick();
    check("alu_wctrl", 64'(wCtrl), 64'd1);
    check("alu_wsel", 64'(wSel), 64'd5);
    check("alu_wdata", 64'(wData), 64'h1234_5678);
    alu_in(5'd0, 32'hDEAD_BEEF);
    tick();
    check("alu_x0_wctrl", 64'(wCtrl), 64'd0);
    check("alu_x0_wsel", 64'(wSel), 64'd5);
    check("alu_x0_wdata", 64'(wData), 64'h1234_5678);
    idle();

    // Load formatting
    for (int i = 0; i < 5; i++) begin
      load_in(5'(10 + i), fv_f3[i], fv_lo[i], 32'h80FF_7F81);
      check("fmt_ready", 64'(ld_ready), 64'd1);
      tick();
      idle();
      check("fmt_wctrl", 64'(wCtrl), 64'd1);
      check("fmt_wsel", 64'(wSel), 64'(10 + i));
      check("fmt_wdata", 64'(wData), 64'(fv_exp[i]));
    end

    // Scoreboard set, clear, set-wins and x0 issue
    issue(5'd7);
    tick();
    idle();
    check("sb_set", 64'(pend_mask), 64'h80);
    load_in(5'd7, 3'b010, 2'd0, 32'h0000_00A5);
    tick();
    idle();
    check("sb_clr_wctrl", 64'(wCtrl), 64'd1);
    check("sb_clr_wdata", 64'(wData), 64'hA5);
    check("sb_clr", 64'(pend_mask), 64'h0);
    issue(5'd7);
    tick();
    load_in(5'd7, 3'b010, 2'd0, 32'h0000_00A6);
    issue(5'd7);
    tick();
    idle();
    check("sb_setwins", 64'(pend_mask), 64'h80);
    check("sb_setwins_wctrl", 64'(wCtrl), 64'd1);
    load_in(5'd7, 3'b010, 2'd0, 32'h0000_00A7);
    tick();
    idle();
    check("sb_clr2", 64'(pend_mask), 64'h0);
    issue(5'd0);
    tick();
    idle();
    check("sb_x0", 64'(pend_mask), 64'h0);

    // Misaligned LW and illegal funct3
    issue(5'd8);
    tick();
    idle();
    check("err1_pend_set", 64'(pend_mask), 64'h100);
    load_in(5'd8, 3'b010, 2'd2, 32'h1111_1111);
    tick();
    idle();
    check("err1_pulse", 64'(ld_err), 64'd1);
    check("err1_wctrl", 64'(wCtrl), 64'd0);
    check("err1_pend", 64'(pend_mask), 64'h0);
    tick();
    check("err1_once", 64'(ld_err), 64'd0);
    issue(5'd9);
    tick();
    load_in(5'd9, 3'b011, 2'd0, 32'h2222_2222);
    ld_issue = 1'b0;
    tick();
    idle();
    check("err2_pulse", 64'(ld_err), 64'd1);
    check("err2_wctrl", 64'(wCtrl), 64'd0);
    check("err2_pend", 64'(pend_mask), 64'h0);
    tick();
    check("err2_once", 64'(ld_err), 64'd0);

    // Collision: ALU x3 held three cycles alongside load x4
    issue(5'd4);
    tick();
    idle();
    alu_in(5'd3, 32'h33);
    load_in(5'd4, 3'b010, 2'd0, 32'h4444_4444);
    tick();
    idle();
    check("col_n1_wsel", 64'(wSel), 64'd3);
    check("col_n1_wdata", 64'(wData), 64'h33);
    check("col_n1_ready", 64'(ld_ready), 64'd0);
    alu_in(5'd3, 32'h34);
    tick();
    check("col_n2_wdata", 64'(wData), 64'h34);
    check("col_n2_ready", 64'(ld_ready), 64'd0);
    alu_in(5'd3, 32'h35);
    tick();
    idle();
    check("col_n3_wdata", 64'(wData), 64'h35);
    check("col_n3_ready", 64'(ld_ready), 64'd0);
    check("col_n3_pend", 64'(pend_mask), 64'h10);
    tick();
    check("col_n4_wctrl", 64'(wCtrl), 64'd1);
    check("col_n4_wsel", 64'(wSel), 64'd4);
    check("col_n4_wdata", 64'(wData), 64'h4444_4444);
    check("col_n4_pend", 64'(pend_mask), 64'h0);
    tick();
    check("col_n5_ready", 64'(ld_ready), 64'd1);
    check("col_n5_wctrl", 64'(wCtrl), 64'd0);

    // Asynchronous reset with a full buffer
    issue(5'd4);
    tick();
    idle();
    alu_in(5'd3, 32'h55);
    load_in(5'd4, 3'b010, 2'd0, 32'h7777_7777);
    tick();
    idle();
    alu_in(5'd3, 32'h56);
    check("arst_pre_pend", 64'(pend_mask), 64'h10);
    check("arst_pre_ready", 64'(ld_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_wctrl", 64'(wCtrl), 64'd0);
    check("arst_pend", 64'(pend_mask), 64'h0);
    check("arst_ready", 64'(ld_ready), 64'd0);
    idle();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("arst_rel_ready", 64'(ld_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_write", 64'(wCtrl), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
